// File: rtl/vmicro16_uart_pkg.sv
// Shared definitions for the vmicro16 UART transmit path: defaults, FSM encoding
// and a constant-width helper used to size index fields.
package vmicro16_uart_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Index width for n items; never returns less than 1 so single-bit
    // fields stay legal for the smallest configurations.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last + 1),
// wrapping, found by masking a doubled request vector and isolating its lowest set bit.
module rr_pick
    import vmicro16_uart_pkg::*;
#(
    parameter int CORES = 2,
    parameter int IDX_W = clog2(CORES)
) (
    input  logic [CORES-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [CORES-1:0] onehot,
    output logic             any
);

    logic [2*CORES-1:0] dbl;
    logic [2*CORES-1:0] mask;
    logic [2*CORES-1:0] masked;
    logic [2*CORES-1:0] lowest;
    logic [IDX_W:0]     start;

    always_comb begin
        start  = {1'b0, last} + (IDX_W+1)'(1);
        dbl    = {req, req};
        // start never exceeds CORES, so the upper copy always holds every core
        mask   = {(2*CORES){1'b1}} << start;
        masked = dbl & mask;
        lowest = masked & (~masked + (2*CORES)'(1));
        onehot = lowest[CORES-1:0] | lowest[2*CORES-1:CORES];
        any    = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer among CORES requesters; a grant is held for a
// whole message and released on the last byte or by the stall watchdog.
module uart_tx_arbiter
    import vmicro16_uart_pkg::*;
#(
    parameter int CORES   = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CORES-1:0]        req_valid,
    input  logic [CORES*DATA_W-1:0] req_data,
    input  logic [CORES-1:0]        req_last,
    output logic [CORES-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [CORES-1:0]        grant,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDX_W = clog2(CORES);

    state_e             state_q, state_d;
    logic [CORES-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic               timeout_q, timeout_d;

    logic [CORES-1:0]   pick_onehot;
    logic               pick_any;
    logic [IDX_W-1:0]   g_idx;
    logic               g_valid;
    logic               g_last;
    logic               xfer;
    logic               release_ok;
    logic               expire;

    rr_pick #(
        .CORES (CORES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .last   (last_q),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < CORES; i++) begin
            if (grant_q[i]) g_idx = IDX_W'(i);
        end
        g_valid    = |(req_valid & grant_q);
        g_last     = |(req_last & grant_q);
        xfer       = (state_q == ST_LOCK) && g_valid && tx_ready;
        release_ok = xfer && g_last;
        // Fires on the cycle that would bring the idle count to TIMEOUT
        expire     = (TIMEOUT != 0) && (state_q == ST_LOCK) && !g_valid
                     && (wdog_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(CORES - 1);
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_any) state_d = ST_LOCK;
            ST_LOCK: if (release_ok || expire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    wdog_d  = '0;
                end
            end
            ST_LOCK: begin
                // Normal release takes priority over a coincident expiry
                if (release_ok) begin
                    grant_d = '0;
                    last_d  = g_idx;
                    wdog_d  = '0;
                end else if (expire) begin
                    grant_d   = '0;
                    last_d    = g_idx;
                    wdog_d    = '0;
                    timeout_d = 1'b1;
                end else if (g_valid) begin
                    wdog_d = '0;
                end else if ((TIMEOUT != 0) && (wdog_q != CNT_W'(TIMEOUT))) begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state_q == ST_LOCK) begin
            tx_valid  = g_valid;
            req_ready = grant_q & {CORES{tx_ready}};
            for (int i = 0; i < CORES; i++) begin
                if (grant_q[i]) tx_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == ST_LOCK);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (2 cores, watchdog of 10 idle cycles):
// a cycle table for arbitration/data path plus hand sequences for multi-cycle cases.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;

    int n_checks;
    int n_fail;

    uart_tx_arbiter #(
        .CORES   (2),
        .DATA_W  (8),
        .TIMEOUT (10),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] l;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] g;
        logic       txv;
        logic [7:0] txd;
        logic [1:0] rr;
        logic       bsy;
        logic       to;
    } vec_t;

    localparam int NVEC = 14;
    vec_t tbl [0:NVEC-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] l,
                         input logic [7:0] d0, input logic [7:0] d1, input logic rdy);
        req_valid = v;
        req_last  = l;
        req_data  = {d1, d0};
        tx_ready  = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},    32'(grant),     32'h0);
        check({tag, "_busy"},     32'(busy),      32'h0);
        check({tag, "_txv"},      32'(tx_valid),  32'h0);
        check({tag, "_txd"},      32'(tx_data),   32'h0);
        check({tag, "_rdy"},      32'(req_ready), 32'h0);
        check({tag, "_timeout"},  32'(timeout),   32'h0);
    endtask

    initial begin
        int bad;
        int msgs;
        int ec;
        int bidx [0:1];

        n_checks = 0;
        n_fail   = 0;

        // v     l      d0     d1     rdy  | g     txv   txd    rr     bsy   to
        tbl[0]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 8'hA0, 8'hB0, 1'b1, 2'b01, 1'b1, 8'hA0, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 2'b01, 8'hA1, 8'hB0, 1'b1, 2'b01, 1'b1, 8'hA1, 2'b01, 1'b1, 1'b0};
        tbl[3]  = '{2'b10, 2'b00, 8'h00, 8'hB0, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{2'b11, 2'b00, 8'hC0, 8'hB0, 1'b0, 2'b10, 1'b1, 8'hB0, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 2'b00, 8'hC0, 8'hB0, 1'b1, 2'b10, 1'b1, 8'hB0, 2'b10, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 2'b10, 8'hC0, 8'hB1, 1'b1, 2'b10, 1'b1, 8'hB1, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b1, 2'b01, 1'b1, 8'h41, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b1, 2'b01, 1'b1, 8'h42, 2'b01, 1'b1, 1'b0};
        tbl[10] = '{2'b01, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 1'b1, 8'h0A, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{2'b01, 2'b00, 8'h33, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[12] = '{2'b01, 2'b01, 8'h33, 8'h00, 1'b1, 2'b01, 1'b1, 8'h33, 2'b01, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};

        reset = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Contention, stall, ignored mid-lock request, single-core message, same-core gap
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].l, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d_grant", i), 32'(grant),     32'(tbl[i].g));
            check($sformatf("vec%0d_txv", i),   32'(tx_valid),  32'(tbl[i].txv));
            check($sformatf("vec%0d_txd", i),   32'(tx_data),   32'(tbl[i].txd));
            check($sformatf("vec%0d_rdy", i),   32'(req_ready), 32'(tbl[i].rr));
            check($sformatf("vec%0d_busy", i),  32'(busy),      32'(tbl[i].bsy));
            check($sformatf("vec%0d_to", i),    32'(timeout),   32'(tbl[i].to));
        end

        // Fairness: both cores stream 2-byte messages; core c byte b carries 8'h{c}{b}
        do_reset();
        bidx[0] = 0;
        bidx[1] = 0;
        msgs    = 0;
        for (int cyc = 0; cyc < 200 && msgs < 8; cyc++) begin
            @(negedge clk);
            drive(2'b11, {bidx[1] == 1, bidx[0] == 1},
                  8'(bidx[0]), 8'(8'h10 + bidx[1]), 1'b1);
            #1;
            if (tx_valid) begin
                ec = msgs % 2;
                check($sformatf("fair_msg%0d_grant", msgs), 32'(grant), 32'(1 << ec));
                check($sformatf("fair_msg%0d_data", msgs), 32'(tx_data), 32'(ec * 16 + bidx[ec]));
                if (bidx[ec] == 1) begin
                    bidx[ec] = 0;
                    msgs++;
                end else begin
                    bidx[ec] = 1;
                end
            end else begin
                check("fair_gap_grant", 32'(grant), 32'h0);
            end
        end
        check("fair_msg_count", 32'(msgs), 32'd8);

        // Backpressure for 300 cycles with valid held: watchdog must stay quiet
        do_reset();
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, 8'hB0, 1'b0);
        #1;
        check("bp_idle_grant", 32'(grant), 32'h0);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (grant !== 2'b10 || timeout !== 1'b0 || tx_valid !== 1'b1 || req_ready !== 2'b00)
                bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, 8'hB0, 1'b1);
        #1;
        check("bp_b0_data", 32'(tx_data), 32'hB0);
        check("bp_b0_rdy",  32'(req_ready), 32'h2);
        @(negedge clk);
        drive(2'b10, 2'b10, 8'h00, 8'hB1, 1'b1);
        #1;
        check("bp_b1_data", 32'(tx_data), 32'hB1);
        @(negedge clk);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        #1;
        check("bp_done_grant",   32'(grant), 32'h0);
        check("bp_done_timeout", 32'(timeout), 32'h0);

        // Watchdog: core 1 sends one byte without last, then stalls; core 0 waits
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, 8'h55, 1'b1);
        #1;
        check("wd_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        check("wd_byte_grant", 32'(grant), 32'h2);
        check("wd_byte_data",  32'(tx_data), 32'h55);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(2'b01, 2'b00, 8'h77, 8'h00, 1'b1);
            #1;
            if (grant !== 2'b10 || timeout !== 1'b0) bad++;
        end
        check("wd_hold_bad_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        #1;
        check("wd_fire_timeout", 32'(timeout), 32'h1);
        check("wd_fire_grant",   32'(grant), 32'h0);
        check("wd_fire_busy",    32'(busy), 32'h0);
        @(negedge clk);
        #1;
        check("wd_next_grant",   32'(grant), 32'h1);
        check("wd_next_timeout", 32'(timeout), 32'h0);
        check("wd_next_data",    32'(tx_data), 32'h77);

        // Asynchronous reset during the second byte of a core 1 message
        do_reset();
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, 8'hD0, 1'b1);
        @(negedge clk);
        #1;
        check("rst_b0_grant", 32'(grant), 32'h2);
        @(negedge clk);
        drive(2'b10, 2'b00, 8'h00, 8'hD1, 1'b1);
        #1;
        check("rst_b1_data", 32'(tx_data), 32'hD1);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(2'b11, 2'b00, 8'hE0, 8'hD1, 1'b1);
        #1;
        check("rst_after_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        check("rst_after_grant", 32'(grant), 32'h1);
        check("rst_after_data",  32'(tx_data), 32'hE0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the SoC's single UART transmitter between CORES vmicro16 cores, so one TXD pin carries messages from every core without interleaving bytes. Each core presents a byte stream with an end-of-message marker. The arbiter grants the transmitter round-robin and holds the grant for a whole message. A watchdog releases a grant held by a core that stalls mid-message. It sits inside vmicro16_soc, between the per-core UART request ports and the UART TX serializer whose output drives uart_tx.

Parameters:
CORES, 2, number of requesting cores (2..8)
DATA_W, 8, byte width of the data path
TIMEOUT, 255, idle cycles tolerated mid-message before a forced release; 0 disables the watchdog
CNT_W, 8, width of the watchdog counter; TIMEOUT must fit in CNT_W

Ports:
clk  in  1  system clock; all state in this block is clocked by this single clock
reset  in  1  asynchronous, active-high reset
req_valid  in  CORES  per-core byte valid
req_data  in  CORES*DATA_W  per-core byte; core i occupies bits [i*DATA_W +: DATA_W]
req_last  in  CORES  per-core marker: this byte ends the message
req_ready  out  CORES  per-core accept
tx_valid  out  1  byte valid to the serializer
tx_data  out  DATA_W  byte to the serializer
tx_ready  in  1  serializer accept
grant  out  CORES  one-hot grant, all-zero when idle
busy  out  1  high while a grant is held
timeout  out  1  one-cycle pulse on a forced release

Behaviour:
- Reset values: grant=0, busy=0, timeout=0, tx_valid=0, tx_data=0, req_ready=0, state=IDLE, watchdog count=0, last_grant=CORES-1 (core 0 has first priority after reset).
- Handshake: a byte transfers in any cycle where tx_valid && tx_ready. The data path is combinational while a grant is held (state LOCK):
  - tx_valid = req_valid[g]
  - tx_data = req_data[g]
  - req_ready[g] = tx_ready
  - req_ready of every non-granted core = 0
  - in IDLE: tx_valid=0, tx_data=0, all req_ready=0
- FSM states are IDLE and LOCK.
- IDLE: if any req_valid is high, pick the first requester at or after (last_grant+1) mod CORES. Register its one-hot grant, set busy=1, clear the watchdog, and move to LOCK. Grant latency is one cycle: a request sampled at edge N is granted after edge N, and its first byte can transfer in cycle N+1.
- LOCK, normal release: a transfer with req_last[g]=1 moves the FSM to IDLE at the next edge. That edge sets last_grant=g, grant=0 and busy=0.
- Gap between messages: at least one IDLE cycle separates consecutive messages, even from the same core.
- Watchdog: in LOCK the counter increments on each cycle with req_valid[g]=0. It clears on any cycle with req_valid[g]=1, including cycles stalled by tx_ready=0; backpressure never trips it.
- Forced release: when the count reaches TIMEOUT, go to IDLE with last_grant=g and pulse timeout for exactly one cycle, aligned with grant dropping. Any partial message is abandoned; a later byte from that core starts a new arbitration. With TIMEOUT=0 the counter is held at 0 and never fires.
- Simultaneous events:
  - Normal release and watchdog expiry in the same cycle: normal release wins and timeout stays 0.
  - New requests arriving during LOCK are ignored until IDLE.
  - A core that drops req_valid mid-message without req_last keeps the grant until the watchdog fires.
- Reset mid-message: asynchronous clear to the reset values. An in-flight byte is lost. The serializer is reset by the same signal.
- Counter width: the watchdog saturates at TIMEOUT and never wraps.

Decomposition:
- Shared package vmicro16_uart_pkg:
  - DATA_W default
  - state encoding (IDLE=1'b0, LOCK=1'b1)
  - function clog2
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[CORES], last[clog2(CORES)]
  - Outputs: onehot[CORES], any
  - Implement as a doubled-vector mask with a priority encoder.
- uart_tx_arbiter holds the FSM, grant register, last_grant, the watchdog and the data mux.

Test Plan:
1. Single core, CORES=2: core 0 sends 3 bytes 0x41,0x42,0x0A with last on 0x0A, tx_ready=1 → grant=2'b01 one cycle after valid; tx_data shows 0x41,0x42,0x0A on consecutive cycles; grant=0 on the cycle after 0x0A.
2. Contention: both cores raise valid in the same cycle just after reset → core 0 sends its whole message first, then after exactly one IDLE cycle grant=2'b10; the bytes of the two messages never interleave.
3. Fairness: core 0 and core 1 request continuously, each sending 2-byte messages → grant alternates 01,10,01,10 over 8 messages.
4. Backpressure: tx_ready=0 for 300 cycles mid-message while req_valid is held high, TIMEOUT=255 → timeout never pulses; the message completes once tx_ready=1.
5. Watchdog: core 1 sends 1 byte without last, then drops valid, TIMEOUT=10 → timeout pulses once, 10 cycles after valid drops, grant→0; a pending core 0 request is granted on the next cycle.
6. Reset mid-message: assert reset during the 2nd byte of a message from core 1 → all outputs 0 immediately (asynchronous); after release, simultaneous requests are granted to core 0 first.
